// File: rtl/multi_delay_line_if.sv
// Sample/control bundle for the multi-channel delay line.
// The producer side (sample source plus tap configuration) uses the master modport.
// The delay line itself uses the slave modport.
interface multi_delay_line_if #(
  parameter int WIDTH = 13,
  parameter int NCH   = 2,
  parameter int TAP_W = 6,
  parameter int CH_W  = 1
);
  logic                   ce;
  logic [NCH*WIDTH-1:0]   din;
  logic [NCH-1:0]         bypass;
  logic                   tap_wr;
  logic [CH_W-1:0]        tap_ch;
  logic [TAP_W-1:0]       tap_val;
  logic [NCH*WIDTH-1:0]   dout;
  logic [NCH-1:0]         dout_valid;

  modport master (
    output ce, din, bypass, tap_wr, tap_ch, tap_val,
    input  dout, dout_valid
  );

  modport slave (
    input  ce, din, bypass, tap_wr, tap_ch, tap_val,
    output dout, dout_valid
  );
endinterface

// File: rtl/multi_delay_line.sv
// Multi-channel programmable delay line for signed sample streams.
// Each channel delays its input by a runtime tap of 0..DEPTH ce-cycles.
// Until the line has seen enough real samples for the current tap, the output
// is forced to zero and flagged invalid.
// Line storage carries no reset so it can map onto shift-register primitives.
// Stale contents are masked by the per-channel fill counter instead.
module multi_delay_line #(
  parameter int WIDTH    = 13,
  parameter int DEPTH    = 32,
  parameter int NCH      = 2,
  parameter int TAP_W    = 6,
  parameter int CH_W     = 1,
  parameter int TAP_INIT = 0
) (
  input  logic clk,
  input  logic rst,
  multi_delay_line_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DEPTH);

  // Requested tap clamped to the physical line length; shared by all channels.
  logic [TAP_W-1:0] tap_req;
  assign tap_req = (bus.tap_val > TAP_MAX) ? TAP_MAX : bus.tap_val;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] line_q [DEPTH];
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] fill_q;
    logic             byp_q;
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;
    logic [WIDTH-1:0] din_c;
    logic [WIDTH-1:0] sel;
    logic             ok;
    logic             tap_hit;
    logic [IDX_W-1:0] rd_idx;

    assign din_c = bus.din[c*WIDTH +: WIDTH];
    // A full-width compare means out-of-range channel numbers match no channel.
    assign tap_hit = bus.tap_wr && (32'(bus.tap_ch) == c);
    // Only meaningful when tap_q is non-zero; the zero case takes the input path.
    assign rd_idx  = IDX_W'(tap_q - TAP_W'(1));

    // Sample storage: shifts only on ce, never reset.
    always_ff @(posedge clk) begin
      if (bus.ce) begin
        line_q[0] <= din_c;
        for (int i = 1; i < DEPTH; i++) begin
          line_q[i] <= line_q[i-1];
        end
      end
    end

    // Tap selection and fill qualification from pre-edge register values.
    always_comb begin
      sel = din_c;
      ok  = 1'b1;
      if (!byp_q && (tap_q != '0)) begin
        sel = line_q[rd_idx];
        ok  = (fill_q >= tap_q);
      end
    end

    // Control registers and the registered output stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        tap_q  <= TAP_W'(TAP_INIT);
        byp_q  <= 1'b1;
        fill_q <= '0;
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        byp_q <= bus.bypass[c];
        if (tap_hit) begin
          tap_q <= tap_req;
        end
        if (bus.ce) begin
          dout_q <= ok ? sel : '0;
          vld_q  <= ok;
          if (fill_q != TAP_MAX) begin
            fill_q <= fill_q + TAP_W'(1);
          end
        end
      end
    end

    assign bus.dout[c*WIDTH +: WIDTH] = dout_q;
    assign bus.dout_valid[c]          = vld_q;
  end

endmodule

// File: tb/tb_multi_delay_line.sv
// Directed bench for multi_delay_line: three channels so an out-of-range
// channel select is expressible, and a non-zero reset tap.
module tb_multi_delay_line;
  localparam int WIDTH    = 13;
  localparam int DEPTH    = 32;
  localparam int NCH      = 3;
  localparam int TAP_W    = 6;
  localparam int CH_W     = 2;
  localparam int TAP_INIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_delay_line_if #(.WIDTH(WIDTH), .NCH(NCH), .TAP_W(TAP_W), .CH_W(CH_W)) bus ();

  multi_delay_line #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH), .TAP_W(TAP_W), .CH_W(CH_W), .TAP_INIT(TAP_INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int k;                          // ce edges since the last reset
  int tap_m [NCH];                // tap in effect at the next edge
  bit byp_m [NCH];                // registered bypass in effect at the next edge
  logic [WIDTH-1:0] exp_d [NCH];
  logic [WIDTH-1:0] exp_v [NCH];

  // Sample j (1-based, counted in ce edges) of channel ch.
  function automatic logic [WIDTH-1:0] v(int ch, int j);
    if (ch == 0) return WIDTH'(j);
    if (ch == 1) return WIDTH'(100 + j);
    return WIDTH'(-j);
  endfunction

  task automatic chk(string tag, int ch, logic [WIDTH-1:0] got, logic [WIDTH-1:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s ch%0d: observed %0h expected %0h", tag, ch, got, expv);
    end
  endtask

  // One clock: drive din, advance, update the expectation, check every channel.
  task automatic tick();
    for (int c = 0; c < NCH; c++) begin
      if (bus.ce) bus.din[c*WIDTH +: WIDTH] = v(c, k + 1);
      else        bus.din[c*WIDTH +: WIDTH] = 13'h1555;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      for (int c = 0; c < NCH; c++) begin
        exp_d[c] = '0;
        exp_v[c] = '0;
        tap_m[c] = TAP_INIT;
        byp_m[c] = 1'b1;
      end
    end else begin
      if (bus.ce) begin
        k++;
        for (int c = 0; c < NCH; c++) begin
          if (byp_m[c] || tap_m[c] == 0) begin
            exp_d[c] = v(c, k);
            exp_v[c] = 1;
          end else if (k - 1 >= tap_m[c]) begin
            exp_d[c] = v(c, k - tap_m[c]);
            exp_v[c] = 1;
          end else begin
            exp_d[c] = '0;
            exp_v[c] = '0;
          end
        end
      end
      if (bus.tap_wr && int'(bus.tap_ch) < NCH)
        tap_m[int'(bus.tap_ch)] = (int'(bus.tap_val) > DEPTH) ? DEPTH : int'(bus.tap_val);
      for (int c = 0; c < NCH; c++) byp_m[c] = bus.bypass[c];
    end
    for (int c = 0; c < NCH; c++) begin
      chk("dout", c, bus.dout[c*WIDTH +: WIDTH], exp_d[c]);
      chk("valid", c, WIDTH'(bus.dout_valid[c]), exp_v[c]);
    end
  endtask

  initial begin
    bit ce_pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    k = 0;
    for (int c = 0; c < NCH; c++) begin
      tap_m[c] = TAP_INIT;
      byp_m[c] = 1'b1;
      exp_d[c] = '0;
      exp_v[c] = '0;
    end

    // Reset with ce and a tap write active: reset wins.
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.bypass = '0;
    bus.tap_wr = 1'b1;
    bus.tap_ch = 2'd0;
    bus.tap_val = 6'd7;
    bus.din = '0;
    tick();
    tick();
    chk("rst_dout", 0, bus.dout[0 +: WIDTH], 13'd0);
    chk("rst_valid", 0, WIDTH'(bus.dout_valid[0]), 13'd0);

    // Configure with ce low: ch0=3, ch1=63 (clamps to 32), ch2=0, ch3 ignored.
    rst = 1'b0;
    bus.ce = 1'b0;
    bus.tap_wr = 1'b0;
    tick();
    bus.tap_wr = 1'b1;
    bus.tap_ch = 2'd0; bus.tap_val = 6'd3;  tick();
    bus.tap_ch = 2'd1; bus.tap_val = 6'd63; tick();
    bus.tap_ch = 2'd2; bus.tap_val = 6'd0;  tick();
    bus.tap_ch = 2'd3; bus.tap_val = 6'd5;  tick();
    bus.tap_wr = 1'b0;

    // Continuous ramp.
    bus.ce = 1'b1;
    repeat (3) tick();
    chk("fill_gap_ch0", 0, WIDTH'(bus.dout_valid[0]), 13'd0);
    chk("tap0_ch2", 2, bus.dout[2*WIDTH +: WIDTH], 13'h1FFD);
    tick();
    chk("first_valid_ch0", 0, bus.dout[0 +: WIDTH], 13'd1);
    repeat (32) tick();
    chk("ramp_ch0", 0, bus.dout[0 +: WIDTH], 13'd33);
    chk("clamp32_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd104);

    // Bypass on ch1 takes effect one edge after it is registered.
    bus.bypass[1] = 1'b1;
    tick();
    chk("byp_pipe_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd105);
    tick();
    chk("byp_on_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd138);
    bus.bypass[1] = 1'b0;
    tick();
    tick();
    chk("byp_off_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd108);

    // Tap changes with simultaneous ce: old tap is used on the write edge.
    bus.tap_wr = 1'b1;
    bus.tap_ch = 2'd0; bus.tap_val = 6'd5;
    tick();
    chk("old_tap_ch0", 0, bus.dout[0 +: WIDTH], 13'd38);
    bus.tap_ch = 2'd1; bus.tap_val = 6'd4;
    tick();
    chk("new_tap5_ch0", 0, bus.dout[0 +: WIDTH], 13'd37);
    chk("old_tap32_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd110);
    bus.tap_wr = 1'b0;
    repeat (3) tick();
    bus.tap_wr = 1'b1;
    bus.tap_ch = 2'd0; bus.tap_val = 6'd2;
    tick();
    chk("pre_dec_ch0", 0, bus.dout[0 +: WIDTH], 13'd41);
    bus.tap_wr = 1'b0;
    tick();
    chk("dec_ch0", 0, bus.dout[0 +: WIDTH], 13'd45);
    chk("dec_valid_ch0", 0, WIDTH'(bus.dout_valid[0]), 13'd1);
    chk("tap4_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd143);

    // One-cycle reset mid-stream; taps return to 4.
    rst = 1'b1;
    tick();
    chk("mid_rst_dout", 0, bus.dout[0 +: WIDTH], 13'd0);
    rst = 1'b0;
    bus.ce = 1'b0;
    tick();
    bus.ce = 1'b1;
    repeat (4) tick();
    chk("refill_gap_ch0", 0, WIDTH'(bus.dout_valid[0]), 13'd0);
    tick();
    chk("refill_first_ch0", 0, bus.dout[0 +: WIDTH], 13'd1);
    chk("refill_first_ch2", 2, bus.dout[2*WIDTH +: WIDTH], 13'h1FFF);

    // ce gaps with ch0 at tap 2: delay counts ce edges only.
    bus.ce = 1'b0;
    bus.tap_wr = 1'b1;
    bus.tap_ch = 2'd0; bus.tap_val = 6'd2;
    tick();
    bus.tap_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.ce = ce_pat[i];
      tick();
    end
    chk("ce_gap_ch0", 0, bus.dout[0 +: WIDTH], 13'd10);
    chk("ce_gap_ch1", 1, bus.dout[WIDTH +: WIDTH], 13'd108);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_delay_line.md
# multi_delay_line

Parametrised multi-channel programmable delay line for signed sample streams. Each of NCH channels delays its input by a per-channel tap of 0..DEPTH sample periods, with a registered per-channel bypass. Adds beyond the single-channel version: a clock enable, a runtime tap-write port, tap clamping, and a fill-tracking valid flag that forces zeros until the line holds enough real samples. Sits in the ADC-to-feedback datapath where each channel's sample timing is aligned before downstream arithmetic.

## Interface
- WIDTH, 13, sample width (signed, two's complement)
- DEPTH, 32, maximum delay in samples (≥2); line storage is DEPTH words per channel, SRL-inferable (no reset on storage)
- NCH, 2, channel count (≥1)
- TAP_W, 6, tap field width; must hold DEPTH
- CH_W, 1, channel-select width; must hold NCH-1
- TAP_INIT, 0, tap value loaded into every channel on reset
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  sample enable; line shifts and outputs update only when high
- din  in  NCH*WIDTH  input samples; channel c occupies bits [c*WIDTH +: WIDTH]
- bypass  in  NCH  per-channel bypass request (registered internally before use)
- tap_wr  in  1  tap-write strobe
- tap_ch  in  CH_W  channel addressed by tap_wr
- tap_val  in  TAP_W  requested tap
- dout  out  NCH*WIDTH  delayed samples, registered, same packing as din
- dout_valid  out  NCH  per-channel flag: dout holds a real delayed sample

## Operation
- Per channel c: line[0..DEPTH-1], tap_reg, bypass_reg, fill counter (0..DEPTH, saturating).
- Every clk: bypass_reg <= bypass (one-cycle pipeline, independent of ce).
- Tap write: on tap_wr with tap_ch < NCH, tap_reg[tap_ch] <= min(tap_val, DEPTH). tap_ch ≥ NCH ignored. Write independent of ce; line contents and fill untouched (no flush).
- On ce=1, per channel, using pre-edge register values:
  - line[0] <= din_c; line[i] <= line[i-1] for i=1..DEPTH-1
  - sel = din_c if bypass_reg or tap_reg==0, else line[tap_reg-1]
  - ok = bypass_reg or tap_reg==0 or fill ≥ tap_reg
  - dout_c <= ok ? sel : 0; dout_valid[c] <= ok
  - fill <= min(fill+1, DEPTH)
- On ce=0: line, fill, dout, dout_valid hold.
- Net delay: tap t gives dout_c = din_c from t ce-cycles earlier, registered (tap 0 ≡ bypass = one-register pass-through).
- Reset (rst=1, priority over ce and tap_wr): dout=0, dout_valid=0, fill=0, tap_reg=TAP_INIT, bypass_reg=1. line storage not reset; stale contents masked by fill.
- Reset mid-stream: next ce samples after rst release are treated as first samples; outputs zero/invalid until fill ≥ tap.

## Timing
- Output register: dout/dout_valid change only on the clk edge of a ce=1 cycle (or reset).
- bypass change at edge k affects dout computed at edge k+1 (visible after k+1 edge... i.e. first ce-edge after bypass_reg updates).
- tap_wr at edge k: tap_reg updated at edge k; first used for dout at edge k+1 if ce=1 then.
- Simultaneous tap_wr and ce at same edge: ce uses old tap; new tap from next ce.
- Increasing tap above fill: dout_valid drops to 0 and dout to 0 until fill catches up (only possible within first DEPTH samples after reset).
- Decreasing tap: takes effect immediately, no gap, no zero insertion; samples skipped.
- Throughput: one sample per channel per ce cycle; no back-pressure.

## Test plan
- Reset, ce=1 continuously, bypass=0, tap ch0=3, din ch0 ramp 1,2,3,… from first post-reset ce -> dout ch0 = 0 with valid=0 for first 3 ce edges, then 1,2,3,… with valid=1.
- tap=0 and separately bypass=1 (after 1-cycle pipeline) -> dout equals din of previous cycle, valid=1 from first ce edge after reset.
- ce toggled 1,0,0,1,… with tap=2 -> dout/valid hold through ce=0; delay counted in ce-cycles only, output sequence identical to continuous run.
- tap_wr ch1 tap_val=63 with DEPTH=32 -> tap_reg=32; after ≥32 ce samples dout ch1 = din ch1 delayed 32; tap_ch=NCH (out of range) -> no channel changes.
- Steady state tap 5→2 on ch0 with ch1 at tap 4 -> ch0 jumps to 2-sample delay at next ce edge, valid stays 1; ch1 unaffected; simultaneous tap_wr+ce edge uses old tap.
- Assert rst for one cycle mid-stream with tap=4 -> dout=0, valid=0 next edge; exactly 4 ce samples later valid returns and first valid dout is first post-reset sample.
